// File: rtl/jelly_img_tracker_pkg.sv
// Shared definitions for the mass-center tracker: FSM encoding and full-image ROI helpers.
package jelly_img_tracker_pkg;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_TRACK  = 1'b1;

    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 132;

    // Last inclusive coordinate of a full-image window along one axis
    function automatic int unsigned full_last(input int unsigned size);
        return (size > 0) ? size - 1 : 0;
    endfunction

endpackage

// File: rtl/jelly_img_tracker_window_clamp.sv
// One-axis ROI stage: registers [centre-HALF, centre+HALF] clamped to [0, SIZE-1],
// or the full axis on request, and pulses o_update whenever the range loads.
module jelly_img_tracker_window_clamp
    import jelly_img_tracker_pkg::*;
#(
    parameter int unsigned C_WIDTH = 14,
    parameter int unsigned SIZE    = 640,
    parameter int unsigned HALF    = 64
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cke,
    input  logic               i_load,
    input  logic               i_full,
    input  logic [C_WIDTH-1:0] i_center,
    output logic [C_WIDTH-1:0] o_low,
    output logic [C_WIDTH-1:0] o_high,
    output logic               o_update
);

    localparam int unsigned        CW   = C_WIDTH + 2;
    localparam logic [C_WIDTH-1:0] LAST = C_WIDTH'(full_last(SIZE));

    logic signed [CW-1:0] w_c;
    logic signed [CW-1:0] w_lo;
    logic signed [CW-1:0] w_hi;
    logic [C_WIDTH-1:0]   w_low;
    logic [C_WIDTH-1:0]   w_high;

    logic [C_WIDTH-1:0]   r_low;
    logic [C_WIDTH-1:0]   r_high;
    logic                 r_update;

    // Extra headroom bits keep c-HALF negative-detectable and c+HALF overflow-free
    always_comb begin
        w_c    = signed'({2'b00, i_center});
        w_lo   = w_c - signed'(CW'(HALF));
        w_hi   = w_c + signed'(CW'(HALF));
        w_low  = w_lo[C_WIDTH-1:0];
        w_high = w_hi[C_WIDTH-1:0];
        if (w_lo[CW-1]) begin
            w_low = '0;
        end
        if (w_hi > signed'({2'b00, LAST})) begin
            w_high = LAST;
        end
        if (i_full) begin
            w_low  = '0;
            w_high = LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_low    <= '0;
            r_high   <= LAST;
            r_update <= 1'b0;
        end else if (cke) begin
            r_update <= i_load;
            if (i_load) begin
                r_low  <= w_low;
                r_high <= w_high;
            end
        end
    end

    assign o_low    = r_low;
    assign o_high   = r_high;
    assign o_update = r_update;

endmodule

// File: rtl/jelly_img_mass_center_tracker.sv
// Closed-loop ROI generator fed by per-frame centroids; falls back to full-image search.
// Optional macro JELLY_IMG_TRACKER_IIR_EN enables IIR smoothing of the position in TRACK.
module jelly_img_mass_center_tracker
    import jelly_img_tracker_pkg::*;
#(
    parameter int unsigned Q_WIDTH        = 0,
    parameter int unsigned X_WIDTH        = 14,
    parameter int unsigned Y_WIDTH        = 14,
    parameter int unsigned IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int unsigned WIN_HALF_W     = 64,
    parameter int unsigned WIN_HALF_H     = 32,
    parameter int unsigned LOST_FRAMES    = 4,
    parameter int unsigned LOST_CNT_WIDTH = 8,
    parameter int unsigned IIR_SHIFT      = 2,
    parameter int unsigned INIT_X         = (IMG_WIDTH / 2) << Q_WIDTH,
    parameter int unsigned INIT_Y         = (IMG_HEIGHT / 2) << Q_WIDTH
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cke,
    input  logic                          enable,
    input  logic [X_WIDTH+Q_WIDTH-1:0]    in_x,
    input  logic [Y_WIDTH+Q_WIDTH-1:0]    in_y,
    input  logic                          in_valid,
    input  logic                          frame_end,
    output logic [X_WIDTH-1:0]            out_range_left,
    output logic [X_WIDTH-1:0]            out_range_right,
    output logic [Y_WIDTH-1:0]            out_range_top,
    output logic [Y_WIDTH-1:0]            out_range_bottom,
    output logic                          out_update,
    output logic                          status_track,
    output logic [LOST_CNT_WIDTH-1:0]     status_lost_cnt
);

    localparam int unsigned PX = X_WIDTH + Q_WIDTH;
    localparam int unsigned PY = Y_WIDTH + Q_WIDTH;

`ifdef JELLY_IMG_TRACKER_IIR_EN
    localparam bit IIR_EN = 1'b1;
`else
    localparam bit IIR_EN = 1'b0;
`endif

    localparam logic [PX-1:0] X_MAX_Q = PX'(full_last(IMG_WIDTH) << Q_WIDTH);
    localparam logic [PY-1:0] Y_MAX_Q = PY'(full_last(IMG_HEIGHT) << Q_WIDTH);

    logic [0:0]                r_state;
    logic [PX-1:0]             r_pos_x;
    logic [PY-1:0]             r_pos_y;
    logic                      r_seen;
    logic [LOST_CNT_WIDTH-1:0] r_lost_cnt;
    logic                      r_load;
    logic                      r_full;

    logic [0:0]                w_state_next;
    logic [PX-1:0]             w_pos_x_next;
    logic [PY-1:0]             w_pos_y_next;
    logic                      w_seen_next;
    logic [LOST_CNT_WIDTH-1:0] w_lost_next;
    logic [LOST_CNT_WIDTH-1:0] w_lost_inc;
    logic                      w_load_next;
    logic                      w_full_next;

    logic [PX-1:0]             w_in_x;
    logic [PY-1:0]             w_in_y;
    logic signed [PX:0]        w_dx;
    logic signed [PY:0]        w_dy;
    logic [PX-1:0]             w_trk_x;
    logic [PY-1:0]             w_trk_y;

    logic                      w_update_x;
    logic                      w_update_y;

    // Clamp off-image centroids to the edge, then derive the TRACK-mode position
    always_comb begin
        w_in_x  = (in_x > X_MAX_Q) ? X_MAX_Q : in_x;
        w_in_y  = (in_y > Y_MAX_Q) ? Y_MAX_Q : in_y;
        w_dx    = signed'({1'b0, w_in_x}) - signed'({1'b0, r_pos_x});
        w_dy    = signed'({1'b0, w_in_y}) - signed'({1'b0, r_pos_y});
        w_trk_x = IIR_EN ? PX'(signed'({1'b0, r_pos_x}) + (w_dx >>> IIR_SHIFT)) : w_in_x;
        w_trk_y = IIR_EN ? PY'(signed'({1'b0, r_pos_y}) + (w_dy >>> IIR_SHIFT)) : w_in_y;
    end

    always_comb begin
        w_state_next = r_state;
        w_pos_x_next = r_pos_x;
        w_pos_y_next = r_pos_y;
        w_seen_next  = r_seen;
        w_lost_next  = r_lost_cnt;
        w_load_next  = 1'b0;
        w_full_next  = 1'b0;
        w_lost_inc   = (r_lost_cnt == '1) ? r_lost_cnt : r_lost_cnt + LOST_CNT_WIDTH'(1);

        if (!enable) begin
            w_state_next = ST_SEARCH;
            w_seen_next  = 1'b0;
            w_lost_next  = '0;
            if (r_state == ST_TRACK) begin
                w_load_next = 1'b1;
                w_full_next = 1'b1;
            end
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (in_valid) begin
                        w_state_next = ST_TRACK;
                        w_pos_x_next = w_in_x;
                        w_pos_y_next = w_in_y;
                        w_load_next  = 1'b1;
                        w_seen_next  = !frame_end;
                        w_lost_next  = '0;
                    end else if (frame_end) begin
                        w_seen_next = 1'b0;
                    end
                end
                default: begin
                    if (in_valid) begin
                        w_pos_x_next = w_trk_x;
                        w_pos_y_next = w_trk_y;
                        w_load_next  = 1'b1;
                        w_seen_next  = 1'b1;
                    end
                    // A centroid arriving with frame_end still counts for the closing frame
                    if (frame_end) begin
                        w_seen_next = 1'b0;
                        if (r_seen || in_valid) begin
                            w_lost_next = '0;
                        end else if (32'(w_lost_inc) >= LOST_FRAMES) begin
                            w_state_next = ST_SEARCH;
                            w_lost_next  = '0;
                            w_load_next  = 1'b1;
                            w_full_next  = 1'b1;
                        end else begin
                            w_lost_next = w_lost_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_SEARCH;
            r_pos_x    <= PX'(INIT_X);
            r_pos_y    <= PY'(INIT_Y);
            r_seen     <= 1'b0;
            r_lost_cnt <= '0;
            r_load     <= 1'b0;
            r_full     <= 1'b0;
        end else if (cke) begin
            r_state    <= w_state_next;
            r_pos_x    <= w_pos_x_next;
            r_pos_y    <= w_pos_y_next;
            r_seen     <= w_seen_next;
            r_lost_cnt <= w_lost_next;
            r_load     <= w_load_next;
            r_full     <= w_full_next;
        end
    end

    jelly_img_tracker_window_clamp #(
        .C_WIDTH (X_WIDTH),
        .SIZE    (IMG_WIDTH),
        .HALF    (WIN_HALF_W)
    ) u_clamp_x (
        .clk      (clk),
        .reset_n  (reset_n),
        .cke      (cke),
        .i_load   (r_load),
        .i_full   (r_full),
        .i_center (r_pos_x[PX-1:Q_WIDTH]),
        .o_low    (out_range_left),
        .o_high   (out_range_right),
        .o_update (w_update_x)
    );

    jelly_img_tracker_window_clamp #(
        .C_WIDTH (Y_WIDTH),
        .SIZE    (IMG_HEIGHT),
        .HALF    (WIN_HALF_H)
    ) u_clamp_y (
        .clk      (clk),
        .reset_n  (reset_n),
        .cke      (cke),
        .i_load   (r_load),
        .i_full   (r_full),
        .i_center (r_pos_y[PY-1:Q_WIDTH]),
        .o_low    (out_range_top),
        .o_high   (out_range_bottom),
        .o_update (w_update_y)
    );

    // Both axes load together, so either strobe represents the ROI update
    assign out_update      = w_update_x | w_update_y;
    assign status_track    = r_state[0];
    assign status_lost_cnt = r_lost_cnt;

endmodule
